mac_sequencer: RTL and testbench

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_sequencer.sv | 161 ++++++++++++++++
 tb/tb_mac_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mac_sequencer: streams weight/input/bias beats into a MAC PE, collects results
// Revision 1.0
// ----------------------------------------------------------------------------
module mac_sequencer #(
  parameter int DataWidth      = 32,
  parameter int LenWidth       = 8,
  parameter int MaxOutstanding = 16
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 Start,
  input  logic [LenWidth-1:0]  Len,
  input  logic [DataWidth-1:0] Bias,
  output logic                 Busy,
  output logic                 Done,
  input  logic                 W_SrcValid,
  output logic                 W_SrcRdy,
  input  logic [DataWidth-1:0] W_SrcData,
  input  logic                 I_SrcValid,
  output logic                 I_SrcRdy,
  input  logic [DataWidth-1:0] I_SrcData,
  output logic                 W_DataOutValid,
  input  logic                 W_DataOutRdy,
  output logic [DataWidth-1:0] W_DataOut,
  output logic                 I_DataOutValid,
  input  logic                 I_DataOutRdy,
  output logic [DataWidth-1:0] I_DataOut,
  output logic                 O_DataOutValid,
  input  logic                 O_DataOutRdy,
  output logic [DataWidth-1:0] O_DataOut,
  input  logic                 R_DataInValid,
  output logic                 R_DataInRdy,
  input  logic [DataWidth-1:0] R_DataIn,
  output logic                 Res_Valid,
  output logic [DataWidth-1:0] Res_Data,
  output logic [LenWidth-1:0]  Res_Idx
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // One extra bit so a job of 2^LenWidth-1 elements never wraps.
  localparam int                  CntWidth = LenWidth + 1;
  localparam logic [CntWidth-1:0] MaxOut   = CntWidth'(MaxOutstanding);

  state_t                 state;
  state_t                 state_nxt;
  logic [LenWidth-1:0]    len_q;
  logic [DataWidth-1:0]   bias_q;
  logic [CntWidth-1:0]    issued;
  logic [CntWidth-1:0]    received;
  logic [CntWidth-1:0]    issued_nxt;
  logic [CntWidth-1:0]    received_nxt;
  logic [CntWidth-1:0]    outstanding;
  logic [CntWidth-1:0]    len_ext;
  logic                   in_job;
  logic                   issue_beat;
  logic                   result_beat;
  logic                   job_start;

  assign len_ext      = {1'b0, len_q};
  assign outstanding  = issued - received;
  assign in_job       = (state == ISSUE) || (state == DRAIN);
  assign job_start    = (state == IDLE) && Start;

  // All three PE streams and both sources advance together or not at all.
  assign issue_beat   = (state == ISSUE) && (issued < len_ext) &&
                        W_SrcValid && I_SrcValid &&
                        W_DataOutRdy && I_DataOutRdy && O_DataOutRdy &&
                        (outstanding < MaxOut);
  assign result_beat  = in_job && R_DataInValid;

  assign issued_nxt   = issued   + {{LenWidth{1'b0}}, issue_beat};
  assign received_nxt = received + {{LenWidth{1'b0}}, result_beat};

  assign W_SrcRdy       = issue_beat;
  assign I_SrcRdy       = issue_beat;
  assign W_DataOutValid = issue_beat;
  assign I_DataOutValid = issue_beat;
  assign O_DataOutValid = issue_beat;
  assign W_DataOut      = W_SrcData;
  assign I_DataOut      = I_SrcData;
  assign O_DataOut      = bias_q;

  always_ff @(posedge clk) begin
    if (aclr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    Busy        = 1'b0;
    Done        = 1'b0;
    R_DataInRdy = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          state_nxt = (Len == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        Busy        = 1'b1;
        R_DataInRdy = 1'b1;
        // A final result can land in the same cycle as the last issue.
        if (issued_nxt == len_ext) begin
          state_nxt = (received_nxt == len_ext) ? FINISH : DRAIN;
        end
      end
      DRAIN: begin
        Busy        = 1'b1;
        R_DataInRdy = 1'b1;
        if (received_nxt == len_ext) begin
          state_nxt = FINISH;
        end
      end
      FINISH: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      len_q     <= '0;
      bias_q    <= '0;
      issued    <= '0;
      received  <= '0;
      Res_Valid <= 1'b0;
      Res_Data  <= '0;
      Res_Idx   <= '0;
    end else begin
      Res_Valid <= result_beat;
      if (result_beat) begin
        Res_Data <= R_DataIn;
        Res_Idx  <= received[LenWidth-1:0];
      end
      if (job_start) begin
        len_q    <= Len;
        bias_q   <= Bias;
        issued   <= '0;
        received <= '0;
      end else begin
        issued   <= issued_nxt;
        received <= received_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mac_sequencer: randomized bench with a job-level reference model and PE model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_mac_sequencer;

  localparam int DW   = 16;
  localparam int LW   = 8;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          aclr, Start, Busy, Done;
  logic [LW-1:0] Len;
  logic [DW-1:0] Bias;
  logic          W_SrcValid, W_SrcRdy, I_SrcValid, I_SrcRdy;
  logic [DW-1:0] W_SrcData, I_SrcData;
  logic          W_DataOutValid, W_DataOutRdy, I_DataOutValid, I_DataOutRdy;
  logic          O_DataOutValid, O_DataOutRdy;
  logic [DW-1:0] W_DataOut, I_DataOut, O_DataOut;
  logic          R_DataInValid, R_DataInRdy;
  logic [DW-1:0] R_DataIn;
  logic          Res_Valid;
  logic [DW-1:0] Res_Data;
  logic [LW-1:0] Res_Idx;

  mac_sequencer #(.DataWidth(DW), .LenWidth(LW), .MaxOutstanding(MAXO)) dut (
    .clk(clk), .aclr(aclr), .Start(Start), .Len(Len), .Bias(Bias),
    .Busy(Busy), .Done(Done),
    .W_SrcValid(W_SrcValid), .W_SrcRdy(W_SrcRdy), .W_SrcData(W_SrcData),
    .I_SrcValid(I_SrcValid), .I_SrcRdy(I_SrcRdy), .I_SrcData(I_SrcData),
    .W_DataOutValid(W_DataOutValid), .W_DataOutRdy(W_DataOutRdy), .W_DataOut(W_DataOut),
    .I_DataOutValid(I_DataOutValid), .I_DataOutRdy(I_DataOutRdy), .I_DataOut(I_DataOut),
    .O_DataOutValid(O_DataOutValid), .O_DataOutRdy(O_DataOutRdy), .O_DataOut(O_DataOut),
    .R_DataInValid(R_DataInValid), .R_DataInRdy(R_DataInRdy), .R_DataIn(R_DataIn),
    .Res_Valid(Res_Valid), .Res_Data(Res_Data), .Res_Idx(Res_Idx)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Job-level reference model: job phase, element counts, pending result.
  bit            m_active = 0;
  bit            m_fin    = 0;
  int            m_len    = 0;
  int            m_issued = 0;
  int            m_recv   = 0;
  logic [DW-1:0] m_bias   = '0;
  bit            pend_v   = 0;
  int            pend_idx = 0;
  logic [DW-1:0] pend_data = '0;

  logic [DW-1:0] w_src [256];
  logic [DW-1:0] i_src [256];

  // PE model: results return in order, 'lat' cycles after issue.
  typedef struct packed {
    logic [DW-1:0] res;
    int            due;
  } pe_t;
  pe_t pe_q[$];

  bit            full     = 1;
  int            pv       = 100;
  int            lat      = 1;
  int            iv_block = 0;
  int            or_block = 0;

  int            j_issues, j_dones, j_results, dut_out, peak, first_iss, last_iss;

  bit            nx_aclr  = 0;
  bit            nx_start = 0;
  logic [LW-1:0] nx_len   = '0;
  logic [DW-1:0] nx_bias  = '0;

  task automatic step();
    bit            exp_issue, exp_rbeat, from_q;
    logic [DW-1:0] t;
    @(negedge clk);
    aclr  = nx_aclr;
    Start = nx_start;
    Len   = nx_start ? nx_len  : LW'($urandom);
    Bias  = nx_start ? nx_bias : DW'($urandom);
    W_SrcValid   = full || ($urandom_range(99) < pv);
    I_SrcValid   = full || ($urandom_range(99) < pv);
    W_DataOutRdy = full || ($urandom_range(99) < pv);
    I_DataOutRdy = full || ($urandom_range(99) < pv);
    O_DataOutRdy = full || ($urandom_range(99) < pv);
    if (iv_block > 0) begin
      I_SrcValid = 1'b0;
      iv_block--;
    end else if (or_block > 0) begin
      O_DataOutRdy = 1'b0;
      or_block--;
    end
    W_SrcData = w_src[m_issued % 256];
    I_SrcData = i_src[m_issued % 256];
    from_q = 0;
    if (pe_q.size() > 0 && pe_q[0].due <= cyc && (full || $urandom_range(3) != 0)) begin
      R_DataInValid = 1'b1;
      R_DataIn      = pe_q[0].res;
      from_q        = 1;
    end else begin
      R_DataInValid = !m_active && ($urandom_range(2) == 0);
      R_DataIn      = DW'($urandom);
    end
    #1;
    exp_issue = m_active && (m_issued < m_len) && W_SrcValid && I_SrcValid &&
                W_DataOutRdy && I_DataOutRdy && O_DataOutRdy && ((m_issued - m_recv) < MAXO);
    exp_rbeat = m_active && R_DataInValid;
    check_eq("busy", Busy, m_active);
    check_eq("done", Done, m_fin);
    check_eq("r_rdy", R_DataInRdy, m_active);
    check_eq("w_valid", W_DataOutValid, exp_issue);
    check_eq("i_valid", I_DataOutValid, exp_issue);
    check_eq("o_valid", O_DataOutValid, exp_issue);
    check_eq("w_src_rdy", W_SrcRdy, exp_issue);
    check_eq("i_src_rdy", I_SrcRdy, exp_issue);
    if (exp_issue) begin
      check_eq("w_data", W_DataOut, w_src[m_issued]);
      check_eq("i_data", I_DataOut, i_src[m_issued]);
      check_eq("o_data", O_DataOut, m_bias);
    end
    check_eq("res_valid", Res_Valid, pend_v);
    if (pend_v) begin
      check_eq("res_idx", Res_Idx, pend_idx);
      check_eq("res_data", Res_Data, pend_data);
    end
    // Environment bookkeeping from what the DUT actually drives.
    if (W_DataOutValid && W_DataOutRdy) begin
      j_issues++;
      dut_out++;
      if (first_iss < 0) first_iss = cyc;
      last_iss = cyc;
      t = W_DataOut * I_DataOut + O_DataOut;
      pe_q.push_back('{res: t, due: cyc + lat});
    end
    if (R_DataInValid && R_DataInRdy) dut_out--;
    if (dut_out > peak) peak = dut_out;
    if (from_q && R_DataInRdy) void'(pe_q.pop_front());
    if (Done) j_dones++;
    if (Res_Valid) j_results++;
    // Advance the model across the coming clock edge.
    pend_v = 0;
    if (aclr) begin
      m_active = 0; m_fin = 0; m_issued = 0; m_recv = 0; m_len = 0; m_bias = '0;
      pe_q.delete();
      dut_out = 0;
    end else if (m_fin) begin
      m_fin = 0;
    end else if (m_active) begin
      if (exp_rbeat) begin
        pend_v    = 1;
        pend_idx  = m_recv;
        t         = w_src[m_recv] * i_src[m_recv] + m_bias;
        pend_data = t;
        m_recv++;
      end
      if (exp_issue) m_issued++;
      if (m_recv == m_len) begin
        m_active = 0;
        m_fin    = 1;
      end
    end else if (Start) begin
      m_len = int'(Len); m_bias = Bias; m_issued = 0; m_recv = 0;
      if (Len == '0) m_fin = 1;
      else m_active = 1;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    nx_start = 0;
    repeat (n) step();
  endtask

  task automatic new_words();
    for (int k = 0; k < 256; k++) begin
      w_src[k] = DW'($urandom);
      i_src[k] = DW'($urandom);
    end
  endtask

  task automatic clear_stats();
    j_issues = 0; j_dones = 0; j_results = 0; peak = 0; first_iss = -1; last_iss = -1;
  endtask

  task automatic run_job(input int len, input int bias, input int l, input bit f,
                         input int p, input int restart_at, input bit blk);
    int n;
    new_words();
    lat = l; full = f; pv = p;
    clear_stats();
    nx_start = 1; nx_len = LW'(len); nx_bias = DW'(bias);
    step();
    nx_start = 0;
    if (blk) begin
      iv_block = 3;
      or_block = 2;
    end
    n = 0;
    while ((m_active || m_fin) && n < 3000) begin
      if (n == restart_at) begin
        nx_start = 1; nx_len = LW'(9);
      end else begin
        nx_start = 0;
      end
      step();
      n++;
    end
    nx_start = 0;
    check_eq("job_timeout", n < 3000, 1);
    check_eq("job_issues", j_issues, len);
    check_eq("job_done_pulses", j_dones, 1);
    check_eq("job_results", j_results, len);
    check_eq("busy_after_job", Busy, 0);
  endtask

  task automatic reset_mid_job();
    int n;
    new_words();
    lat = 12; full = 1; pv = 100;
    clear_stats();
    nx_start = 1; nx_len = LW'(5); nx_bias = DW'(11);
    step();
    nx_start = 0;
    n = 0;
    while (m_issued < 2 && n < 50) begin
      step();
      n++;
    end
    check_eq("pre_reset_issues", n < 50, 1);
    nx_aclr = 1;
    step();
    nx_aclr = 0;
    step();
    check_eq("reset_busy", Busy, 0);
    check_eq("reset_res_valid", Res_Valid, 0);
    clear_stats();
    idle(20);
    check_eq("reset_no_done", j_dones, 0);
    check_eq("reset_no_results", j_results, 0);
    run_job(1, 77, 3, 1, 100, -1, 0);
  endtask

  initial begin
    aclr = 1'b1; Start = 1'b0; Len = '0; Bias = '0;
    W_SrcValid = 1'b0; I_SrcValid = 1'b0; W_SrcData = '0; I_SrcData = '0;
    W_DataOutRdy = 1'b0; I_DataOutRdy = 1'b0; O_DataOutRdy = 1'b0;
    R_DataInValid = 1'b0; R_DataIn = '0;
    dut_out = 0;
    clear_stats();
    new_words();
    repeat (3) @(posedge clk);
    nx_aclr = 1;
    step();
    step();
    nx_aclr = 0;
    check_eq("rst_res_data", Res_Data, 0);
    check_eq("rst_res_idx", Res_Idx, 0);
    idle(4);

    // Four back-to-back beats, each carrying the bias.
    run_job(4, 5, 12, 1, 100, -1, 0);
    check_eq("issue_span", last_iss - first_iss, 3);
    idle(2);

    // Empty job.
    run_job(0, 7, 3, 1, 100, -1, 0);
    idle(2);

    // Credit limit with slow returns.
    run_job(10, 3, 12, 1, 100, -1, 0);
    check_eq("peak_outstanding", peak, MAXO);
    idle(2);

    // Source and PE back-pressure at the first beat.
    run_job(3, 9, 2, 1, 100, -1, 1);
    idle(2);

    // Re-pulsed Start mid-job is ignored.
    run_job(5, 2, 4, 1, 100, 2, 0);
    idle(2);

    reset_mid_job();
    idle(2);

    for (int j = 0; j < 20; j++) begin
      run_job($urandom_range(20), int'($urandom), $urandom_range(1, 15), 1'b0,
              $urandom_range(40, 100), ($urandom_range(3) == 0) ? $urandom_range(10) : -1, 1'b0);
      idle($urandom_range(3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
